tx_path: RTL and testbench

- Parallel-to-serial UART transmit path. Accepts a WIDTH_SIZE-bit word over a valid/ready handshake and sends it on a single serial line Tx.
- The word goes out as consecutive UART frames of DATA_BITS each, least-significant chunk first.
- Each frame carries optional even parity and optional error injection for link testing.
- Sits between the host-side word interface and the UART pin.

---
 rtl/tx_path.sv | 153 +++++++++++++++
 tb/tb_tx_path.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tx_path.sv
// UART transmit path: serialises a WIDTH_SIZE-bit word as WIDTH_SIZE/DATA_BITS back-to-back frames.
// Latency: start bit appears on Tx from the accept edge; ready is low for NCHUNK*F*CLKS_PER_BIT cycles.
// Backpressure: ready is low for the whole transfer; valid/input_tx/PF/err are ignored while ready=0.
// Ports: clk, reset (async active-low), valid/input_tx/PF/err (word + per-word config),
//        Tx (registered serial line, idles high), ready (registered, high in IDLE).
`timescale 1ns/1ps
module tx_path #(
  parameter int WIDTH_SIZE   = 32,
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic                  err,
  input  logic [WIDTH_SIZE-1:0] input_tx,
  input  logic                  PF,
  output logic                  Tx,
  output logic                  ready
);

  localparam int NCHUNK = WIDTH_SIZE / DATA_BITS;
  // Counter widths are kept at least 1 bit so degenerate parameters still elaborate.
  localparam int BAW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BTW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int CHW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [BAW-1:0]        baud_q, baud_d;
  logic [BTW-1:0]        bit_q, bit_d;
  logic [CHW-1:0]        chunk_q, chunk_d;
  logic [WIDTH_SIZE-1:0] shift_q, shift_d;
  logic                  pf_q, pf_d;
  logic                  err_q, err_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  bit_done;

  assign Tx    = tx_q;
  assign ready = ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      chunk_q <= '0;
      shift_q <= '0;
      pf_q    <= 1'b0;
      err_q   <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      chunk_q <= chunk_d;
      shift_q <= shift_d;
      pf_q    <= pf_d;
      err_q   <= err_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
    end
  end

  assign bit_done = (baud_q == BAW'(CLKS_PER_BIT - 1));

  // tx_d is the value of the bit the FSM enters, so Tx is a pure register output.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    chunk_d = chunk_q;
    shift_d = shift_q;
    pf_d    = pf_q;
    err_d   = err_q;
    par_d   = par_q;
    tx_d    = tx_q;
    ready_d = ready_q;

    if (state_q == IDLE) begin
      tx_d    = 1'b1;
      ready_d = 1'b1;
      if (valid && ready_q) begin
        state_d = START;
        shift_d = input_tx;
        pf_d    = PF;
        err_d   = err;
        par_d   = 1'b0;
        baud_d  = '0;
        bit_d   = '0;
        chunk_d = '0;
        tx_d    = 1'b0;
        ready_d = 1'b0;
      end
    end else begin
      baud_d = bit_done ? '0 : baud_q + 1'b1;
      if (bit_done) begin
        case (state_q)
          START: begin
            state_d = DATA;
            tx_d    = shift_q[0];
          end
          DATA: begin
            par_d   = par_q ^ shift_q[0];
            shift_d = shift_q >> 1;
            if (bit_q == BTW'(DATA_BITS - 1)) begin
              bit_d = '0;
              if (pf_q) begin
                state_d = PARITY;
                tx_d    = par_d ^ err_q;   // error injection flips parity
              end else begin
                state_d = STOP;
                tx_d    = ~err_q;          // error injection forces a framing error
              end
            end else begin
              bit_d = bit_q + 1'b1;
              tx_d  = shift_d[0];
            end
          end
          PARITY: begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
          STOP: begin
            if (chunk_q == CHW'(NCHUNK - 1)) begin
              chunk_d = '0;
              state_d = IDLE;
              tx_d    = 1'b1;
              ready_d = 1'b1;
            end else begin
              chunk_d = chunk_q + 1'b1;
              state_d = START;
              par_d   = 1'b0;
              tx_d    = 1'b0;  // next start bit follows stop with no gap
            end
          end
          default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            ready_d = 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_path.sv
// Directed bench for tx_path with default parameters (32-bit word, 8-bit frames, 1 clk/bit).
// Outputs are sampled 1 ns after each rising edge; inputs are driven at the same point.
// Serial stream is captured per cycle and compared bit by bit plus against hand-computed frames.
`timescale 1ns/1ps
module tb_tx_path;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic        err = 1'b0;
  logic [31:0] input_tx = '0;
  logic        PF = 1'b0;
  logic        Tx;
  logic        ready;

  int n_tests = 0;
  int n_fail  = 0;
  logic cap [0:63];

  tx_path #(.WIDTH_SIZE(32), .DATA_BITS(8), .CLKS_PER_BIT(1)) dut (
    .clk(clk), .reset(reset), .valid(valid), .err(err),
    .input_tx(input_tx), .PF(PF), .Tx(Tx), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level i cycles after the accept edge.
  function automatic logic exp_bit(input logic [31:0] w, input logic pf, input logic er, input int i);
    int f;
    int c;
    int j;
    logic [7:0] ch;
    f  = pf ? 11 : 10;
    c  = i / f;
    j  = i % f;
    ch = 8'(w >> (c * 8));
    if (j == 0) return 1'b0;
    if (j <= 8) return ch[j-1];
    if (pf && j == 9) return (^ch) ^ er;
    if (pf) return 1'b1;
    return ~er;
  endfunction

  // Called 1 ns after an edge with ready=1. Offers w, checks the whole transfer,
  // disturbs the inputs at cycle 5. With hold=1 valid stays high afterwards.
  task automatic xfer(input logic [31:0] w, input logic pf, input logic er,
                      input logic hold, input logic [31:0] w_mid, input string tag);
    int total;
    total    = pf ? 44 : 40;
    input_tx = w;
    PF       = pf;
    err      = er;
    valid    = 1'b1;
    step();
    if (!hold) valid = 1'b0;
    for (int i = 0; i < total; i++) begin
      cap[i] = Tx;
      check({tag, "_tx"}, 32'(Tx), 32'(exp_bit(w, pf, er, i)));
      check({tag, "_rdy_lo"}, 32'(ready), 32'd0);
      if (i == 5) begin
        input_tx = w_mid;
        if (!hold) begin
          PF  = ~pf;
          err = ~er;
          valid = 1'b1;
        end
      end
      if (i == 6 && !hold) valid = 1'b0;
      step();
    end
    check({tag, "_rdy_end"}, 32'(ready), 32'd1);
    check({tag, "_tx_end"}, 32'(Tx), 32'd1);
  endtask

  initial begin
    logic [9:0] fr;
    logic [7:0] d;

    // Reset held for 20 cycles from power-up.
    for (int i = 0; i < 20; i++) begin
      step();
      check("rst_tx", 32'(Tx), 32'd1);
      check("rst_rdy", 32'(ready), 32'd1);
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_tx", 32'(Tx), 32'd1);
      check("idle_rdy", 32'(ready), 32'd1);
    end

    // Basic word.
    xfer(32'h5555_5555, 1'b0, 1'b0, 1'b0, 32'hFFFF_0000, "basic");
    for (int i = 0; i < 10; i++) fr[9-i] = cap[i];
    check("basic_frame0", 32'(fr), 32'h155);  // 0,1,0,1,0,1,0,1,0,1
    step();
    check("basic_idle", 32'(Tx), 32'd1);

    // Parity enabled: parity of 0x55 is 0.
    xfer(32'h5555_5555, 1'b1, 1'b0, 1'b0, 32'h0, "par");
    check("par_bit0", 32'(cap[9]), 32'd0);
    check("par_stop0", 32'(cap[10]), 32'd1);
    check("par_start1", 32'(cap[11]), 32'd0);

    // Framing-error injection.
    xfer(32'h5555_575D, 1'b0, 1'b1, 1'b0, 32'h1234_5678, "ferr");
    for (int i = 0; i < 8; i++) d[i] = cap[1+i];
    check("ferr_data0", 32'(d), 32'h5D);
    for (int i = 0; i < 8; i++) d[i] = cap[11+i];
    check("ferr_data1", 32'(d), 32'h57);
    for (int k = 0; k < 4; k++) check("ferr_stop", 32'(cap[10*k+9]), 32'd0);

    // Parity-error injection.
    xfer(32'h5555_575D, 1'b1, 1'b1, 1'b0, 32'h0, "perr");
    check("perr_par0", 32'(cap[9]), 32'd0);   // 0x5D: 5 ones -> 1, inverted
    check("perr_par1", 32'(cap[20]), 32'd0);  // 0x57: 5 ones -> 1, inverted
    check("perr_par2", 32'(cap[31]), 32'd1);  // 0x55: 4 ones -> 0, inverted
    check("perr_stop0", 32'(cap[10]), 32'd1);

    // Back-to-back with valid held high; second word presented mid-transfer.
    xfer(32'hA5C3_0F81, 1'b0, 1'b0, 1'b1, 32'h0123_89AB, "b2b_a");
    xfer(32'h0123_89AB, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, "b2b_b");
    for (int i = 0; i < 8; i++) d[i] = cap[1+i];
    check("b2b_b_data0", 32'(d), 32'hAB);

    // Reset mid-frame.
    input_tx = 32'h0000_00FF;
    PF = 1'b0;
    err = 1'b0;
    valid = 1'b1;
    step();
    valid = 1'b0;
    repeat (15) step();
    check("mid_busy", 32'(ready), 32'd0);
    reset = 1'b0;
    #1;
    check("mid_rst_tx", 32'(Tx), 32'd1);
    check("mid_rst_rdy", 32'(ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step();
      check("mid_hold_tx", 32'(Tx), 32'd1);
      check("mid_hold_rdy", 32'(ready), 32'd1);
    end
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      check("post_idle_tx", 32'(Tx), 32'd1);
      check("post_idle_rdy", 32'(ready), 32'd1);
    end
    xfer(32'h3C3C_3C3C, 1'b1, 1'b0, 1'b0, 32'h0, "post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
